// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: loader FSM states and default widths
// matching the processor's program RAM.
package loader_pkg;

    // Program RAM geometry and command field width used by the processor.
    localparam int unsigned DefAddrW = 4;
    localparam int unsigned DefComW  = 2;
    localparam int unsigned DefDataW = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCheck,
        StDone,
        StErr
    } ldr_state_t;

endpackage

// File: rtl/prog_loader.sv
// Program loader: streams a command/operand image into program RAM at consecutive
// addresses, verifies a trailing XOR checksum and holds the CPU in reset until a
// load completes cleanly.
module prog_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned COM_W  = DefComW,
    parameter int unsigned DATA_W = DefDataW
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [COM_W-1:0]  in_com,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [COM_W-1:0]  wr_com,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W:0]   count,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    // Count value when the beat being accepted lands on the top RAM address.
    localparam logic [ADDR_W:0] TopCount = {1'b0, {ADDR_W{1'b1}}};

    ldr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              in_ready_q, in_ready_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [COM_W-1:0]  wr_com_q, wr_com_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              accept;

    // Next-state, write-port and status logic; in_ready is derived from the next state
    // so that it is registered and independent of in_valid.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        count_d   = count_q;
        acc_d     = acc_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_com_d  = wr_com_q;
        wr_data_d = wr_data_q;
        hold_d    = hold_q;
        done_d    = done_q;
        error_d   = error_q;
        accept    = in_valid & in_ready_q;

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d = StLoad;
                    ptr_d   = '0;
                    count_d = '0;
                    acc_d   = '0;
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                end
            end
            StLoad: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ptr_q;
                    wr_com_d  = in_com;
                    wr_data_d = in_data;
                    ptr_d     = ptr_q + 1'b1;
                    count_d   = count_q + 1'b1;
                    acc_d     = acc_q ^ in_data;
                    if (in_last) begin
                        state_d = StCheck;
                    end else if (count_q == TopCount) begin
                        // Image would run past the top of RAM.
                        state_d = StErr;
                        error_d = 1'b1;
                    end
                end
            end
            StCheck: begin
                if (accept) begin
                    if (in_data == acc_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = StErr;
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        in_ready_d = (state_d == StLoad) || (state_d == StCheck);
    end

    // State and output registers with synchronous reset; reset drops any pending write.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            count_q    <= '0;
            acc_q      <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_com_q   <= '0;
            wr_data_q  <= '0;
            hold_q     <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_com_q   <= wr_com_d;
            wr_data_q  <= wr_data_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_com   = wr_com_q;
    assign wr_data  = wr_data_q;
    assign count    = count_q;
    assign cpu_hold = hold_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: randomised beat streams against a behavioural
// model of the load/checksum rules.
module tb_prog_loader;

    localparam int AW    = 4;
    localparam int CW    = 2;
    localparam int DW    = 16;
    localparam int DEPTH = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic [CW-1:0] in_com;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [CW-1:0] wr_com;
    logic [DW-1:0] wr_data;
    logic [AW:0]   count;
    logic          cpu_hold;
    logic          done;
    logic          error;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           wr_q[$];
    wr_t           exp_q[$];
    logic [CW-1:0] s_com[$];
    logic [DW-1:0] s_data[$];
    logic          s_last[$];

    int   checks = 0;
    int   errors = 0;
    int   exp_n;
    logic exp_done;
    logic exp_err;

    always #5 clock = ~clock;

    prog_loader #(
        .ADDR_W(AW),
        .COM_W (CW),
        .DATA_W(DW)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .in_valid(in_valid),
        .in_com  (in_com),
        .in_data (in_data),
        .in_last (in_last),
        .in_ready(in_ready),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_com  (wr_com),
        .wr_data (wr_data),
        .count   (count),
        .cpu_hold(cpu_hold),
        .done    (done),
        .error   (error)
    );

    // Write monitor: records every RAM write seen in a cycle.
    always begin
        @(posedge clock);
        #1;
        if (wr_en === 1'b1) wr_q.push_back({wr_addr, wr_com, wr_data});
    end

    // Reference model: entries go to addresses 0,1,2.. until the first last-flagged
    // entry or the top of RAM; the entry after the last one is the checksum.
    task automatic run_model();
        logic [DW-1:0] acc;
        bit            term;
        acc = '0;
        term = 0;
        exp_q.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        for (int i = 0; i < s_data.size() && !term; i++) begin
            exp_q.push_back({AW'(i), s_com[i], s_data[i]});
            acc = acc ^ s_data[i];
            if (s_last[i]) begin
                term = 1;
                if (i + 1 < s_data.size()) begin
                    exp_done = (s_data[i+1] == acc);
                    exp_err  = !exp_done;
                end
            end else if (i == DEPTH - 1) begin
                term = 1;
                exp_err = 1'b1;
            end
        end
        exp_n = exp_q.size();
    endtask

    // Random image of n entries; optionally last-flagged at the end plus a checksum beat.
    task automatic build_stream(input int n, input bit with_last, input bit good);
        logic [DW-1:0] acc;
        acc = '0;
        s_com.delete();
        s_data.delete();
        s_last.delete();
        for (int i = 0; i < n; i++) begin
            s_com.push_back(CW'($urandom));
            s_data.push_back(DW'($urandom));
            s_last.push_back(with_last && (i == n - 1));
            acc = acc ^ s_data[i];
        end
        if (with_last) begin
            s_com.push_back(CW'($urandom));
            s_data.push_back(good ? acc : (acc ^ DW'($urandom_range(1, 65535))));
            s_last.push_back(1'b0);
        end
    endtask

    // All tasks begin and end 1 time unit after a rising edge.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Offers stream entries [from, to) with random gaps; returns right after the
    // edge that accepts entry to-1.
    task automatic drive_beats(input int gap_pct, input int from, input int to);
        int  i;
        int  idle;
        bit  acc;
        i = from;
        idle = 0;
        while (i < to) begin
            in_valid = ($urandom_range(99) >= gap_pct);
            in_com   = s_com[i];
            in_data  = s_data[i];
            in_last  = s_last[i];
            acc = in_valid && in_ready;
            @(posedge clock);
            #1;
            if (acc) begin
                i++;
                idle = 0;
            end else begin
                idle++;
                if (idle > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_timeout: entry %0d not accepted, in_ready=%b required 1",
                             i, in_ready);
                    break;
                end
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({in_ready, wr_en, wr_addr, wr_com, wr_data, count, done, error, cpu_hold} !==
            {1'b0, 1'b0, 4'h0, 2'h0, 16'h0, 5'h0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_values: rdy=%b we=%b a=%h c=%h d=%h cnt=%0d dn=%b er=%b h=%b",
                     in_ready, wr_en, wr_addr, wr_com, wr_data, count, done, error, cpu_hold,
                     " required rdy=0 we=0 a=0 c=0 d=0 cnt=0 dn=0 er=0 h=1");
        end
        start = 1'b0;
        reset = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if (in_ready !== 1'b0 || cpu_hold !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_reset: in_ready=%b cpu_hold=%b required 0 1",
                     in_ready, cpu_hold);
        end
    endtask

    // Directed three-entry image with good and bad checksums.
    task automatic test_checksum();
        for (int k = 0; k < 2; k++) begin
            s_com  = '{2'd1, 2'd2, 2'd0, 2'd0};
            s_data = '{16'h0005, 16'h0003, 16'h0001, (k == 0) ? 16'h0007 : 16'h0006};
            s_last = '{1'b0, 1'b0, 1'b1, 1'b0};
            run_model();
            wr_q.delete();
            pulse_start();
            drive_beats(0, 0, 1);
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== 4'd0) begin
                errors++;
                $display("FAIL first_write_latency: wr_en=%b addr=%0d required 1 0",
                         wr_en, wr_addr);
            end
            drive_beats(0, 1, 3);
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== 4'd2 || in_ready !== 1'b1 || count !== 5'd3) begin
                errors++;
                $display("FAIL final_write_in_check: we=%b a=%0d rdy=%b cnt=%0d required 1 2 1 3",
                         wr_en, wr_addr, in_ready, count);
            end
            drive_beats(0, 3, 4);
            #2;
            checks++;
            if (wr_q.size() != 3) begin
                errors++;
                $display("FAIL ck%0d_write_count: got %0d required 3", k, wr_q.size());
            end else begin
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if (wr_q[i] !== exp_q[i]) begin
                        errors++;
                        $display("FAIL ck%0d_write%0d: got %h required %h", k, i, wr_q[i],
                                 exp_q[i]);
                    end
                end
            end
            checks++;
            if ({done, error, cpu_hold, count} !== {exp_done, exp_err, !exp_done, 5'd3}) begin
                errors++;
                $display("FAIL ck%0d_status: done=%b error=%b hold=%b count=%0d required %b %b %b 3",
                         k, done, error, cpu_hold, count, exp_done, exp_err, !exp_done);
            end
            @(posedge clock);
            #1;
        end
    endtask

    // Full-RAM images: 16 entries without last (overflow) and with last on the 16th.
    task automatic test_boundary();
        for (int k = 0; k < 2; k++) begin
            build_stream(DEPTH, k == 1, 1'b1);
            run_model();
            wr_q.delete();
            pulse_start();
            drive_beats(30, 0, s_data.size());
            #2;
            checks++;
            if (wr_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL bnd%0d_write_count: got %0d required %0d", k, wr_q.size(),
                         exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    if (wr_q[i] !== exp_q[i]) begin
                        checks++;
                        errors++;
                        $display("FAIL bnd%0d_write%0d: got %h required %h", k, i, wr_q[i],
                                 exp_q[i]);
                        break;
                    end
                end
            end
            checks++;
            if ({done, error, cpu_hold, count, in_ready} !==
                {exp_done, exp_err, !exp_done, 5'(exp_n), 1'b0}) begin
                errors++;
                $display("FAIL bnd%0d_status: dn=%b er=%b h=%b cnt=%0d rdy=%b required %b %b %b %0d 0",
                         k, done, error, cpu_hold, count, in_ready, exp_done, exp_err,
                         !exp_done, exp_n);
            end
            // Nothing more is taken after an overflow.
            repeat (3) @(posedge clock);
            #1;
            checks++;
            if (wr_q.size() != exp_q.size() || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bnd%0d_quiet: writes=%0d rdy=%b required %0d 0", k, wr_q.size(),
                         in_ready, exp_q.size());
            end
        end
    endtask

    // Random gaps, reset part-way through a load, then a fresh random load.
    task automatic test_gaps_reset();
        for (int it = 0; it < 6; it++) begin
            build_stream(8, 1'b1, 1'b1);
            pulse_start();
            drive_beats(40, 0, 2);
            reset = 1'b1;
            @(posedge clock);
            #1;
            checks++;
            if ({in_ready, wr_en, wr_addr, wr_com, wr_data, count, done, error, cpu_hold} !==
                {1'b0, 1'b0, 4'h0, 2'h0, 16'h0, 5'h0, 1'b0, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL it%0d_mid_reset: rdy=%b we=%b a=%h cnt=%0d dn=%b er=%b h=%b required 0 0 0 0 0 0 1",
                         it, in_ready, wr_en, wr_addr, count, done, error, cpu_hold);
            end
            reset = 1'b0;
            build_stream($urandom_range(1, DEPTH), 1'b1, 1'($urandom_range(0, 1)));
            run_model();
            wr_q.delete();
            @(posedge clock);
            #1;
            pulse_start();
            drive_beats(40, 0, s_data.size());
            #2;
            checks++;
            if (wr_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL it%0d_write_count: got %0d required %0d", it, wr_q.size(),
                         exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    if (wr_q[i] !== exp_q[i]) begin
                        checks++;
                        errors++;
                        $display("FAIL it%0d_write%0d: got %h required %h", it, i, wr_q[i],
                                 exp_q[i]);
                        break;
                    end
                end
            end
            checks++;
            if ({done, error, cpu_hold, count} !== {exp_done, exp_err, !exp_done, 5'(exp_n)}) begin
                errors++;
                $display("FAIL it%0d_status: dn=%b er=%b h=%b cnt=%0d required %b %b %b %0d",
                         it, done, error, cpu_hold, count, exp_done, exp_err, !exp_done, exp_n);
            end
            @(posedge clock);
            #1;
        end
    endtask

    // Restart from DONE, and a start pulse in the middle of a load.
    task automatic test_restart();
        build_stream(5, 1'b1, 1'b1);
        pulse_start();
        drive_beats(20, 0, s_data.size());
        checks++;
        if (done !== 1'b1 || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL rs_first_done: done=%b hold=%b required 1 0", done, cpu_hold);
        end
        @(posedge clock);
        #1;
        pulse_start();
        checks++;
        if ({cpu_hold, done, count, in_ready} !== {1'b1, 1'b0, 5'd0, 1'b1}) begin
            errors++;
            $display("FAIL rs_restart: hold=%b done=%b cnt=%0d rdy=%b required 1 0 0 1",
                     cpu_hold, done, count, in_ready);
        end
        build_stream(6, 1'b1, 1'b1);
        run_model();
        wr_q.delete();
        drive_beats(0, 0, 2);
        pulse_start();
        checks++;
        if (count !== 5'd2 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rs_start_in_load: cnt=%0d rdy=%b required 2 1", count, in_ready);
        end
        drive_beats(20, 2, s_data.size());
        #2;
        checks++;
        if (wr_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rs_write_count: got %0d required %0d", wr_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                if (wr_q[i] !== exp_q[i]) begin
                    checks++;
                    errors++;
                    $display("FAIL rs_write%0d: got %h required %h", i, wr_q[i], exp_q[i]);
                    break;
                end
            end
        end
        checks++;
        if ({done, error, cpu_hold, count} !== {1'b1, 1'b0, 1'b0, 5'(exp_n)}) begin
            errors++;
            $display("FAIL rs_status: dn=%b er=%b h=%b cnt=%0d required 1 0 0 %0d",
                     done, error, cpu_hold, count, exp_n);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_com   = '0;
        in_data  = '0;
        in_last  = 1'b0;
        test_reset();
        test_checksum();
        test_boundary();
        test_gaps_reset();
        test_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
